// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing measurement block.
package video_timing_pkg;

   typedef enum logic [1:0] {
      StSearch,
      StMeasure,
      StCheck,
      StLocked
   } state_e;

   localparam int unsigned DefaultHw = 12;
   localparam int unsigned DefaultVw = 11;

   // All-ones value of a counter of the given width (width < 32).
   function automatic int unsigned sat_val(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one control/sync input; the register doubles as the 1-cycle pass-through.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic q_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= d_i;
      end
   end

   assign q_o    = q_q;
   assign rise_o = d_i & ~q_q;
   assign fall_o = ~d_i & q_q;

endmodule

// File: rtl/video_timing_meas.sv
// Measures active/total video timing on the pixel clock and reports a frame-stable lock.
module video_timing_meas
   import video_timing_pkg::*;
#(
   parameter int unsigned HW          = DefaultHw,
   parameter int unsigned VW          = DefaultVw,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dv_i,
   input  logic          hs_i,
   input  logic          vs_i,
   output logic          dv_o,
   output logic          hs_o,
   output logic          vs_o,
   output logic [HW-1:0] x_o,
   output logic [VW-1:0] y_o,
   output logic [HW-1:0] h_active_o,
   output logic [VW-1:0] v_active_o,
   output logic [HW-1:0] h_total_o,
   output logic [VW-1:0] v_total_o,
   output logic          locked_o,
   output logic          fmt_change_o
);

   localparam logic [HW-1:0] HMax = HW'(sat_val(HW));
   localparam logic [VW-1:0] VMax = VW'(sat_val(VW));
   localparam logic [HW-1:0] HOne = HW'(1);
   localparam logic [VW-1:0] VOne = VW'(1);

   logic dv_rise, dv_fall, hs_rise, hs_fall, vs_rise, vs_fall;
   logic unused_fall;

   sync_edge_det u_dv (.clk(clk), .rst(rst), .d_i(dv_i), .q_o(dv_o), .rise_o(dv_rise),
                       .fall_o(dv_fall));
   sync_edge_det u_hs (.clk(clk), .rst(rst), .d_i(hs_i), .q_o(hs_o), .rise_o(hs_rise),
                       .fall_o(hs_fall));
   sync_edge_det u_vs (.clk(clk), .rst(rst), .d_i(vs_i), .q_o(vs_o), .rise_o(vs_rise),
                       .fall_o(vs_fall));

   assign unused_fall = hs_fall ^ vs_fall;

   logic [HW-1:0] x_q, h_cnt_q, h_last_q, ref_q;
   logic [VW-1:0] y_q, v_cnt_q;
   logic          ref_vld_q, bad_q;

   logic [HW-1:0] line_len, f_ha, f_ht;
   logic [VW-1:0] f_va, f_vt;
   logic          line_bad, f_ok, watchdog;

   // Frame values as they stand at a vs rise, folding in events of that same cycle.
   always_comb begin
      line_len = x_q + HOne;
      line_bad = (x_q == HMax) || (ref_vld_q && (line_len != ref_q));
      f_ha     = (dv_fall && !ref_vld_q) ? line_len : ref_q;
      f_va     = (dv_fall && (y_q != VMax)) ? y_q + VOne : y_q;
      f_vt     = (hs_rise && (v_cnt_q != VMax)) ? v_cnt_q + VOne : v_cnt_q;
      f_ht     = hs_rise ? h_cnt_q : h_last_q;
      f_ok     = (ref_vld_q || dv_fall) && !bad_q && !(dv_fall && line_bad) && !dv_i &&
                 (f_va != VMax) && (f_vt != VMax) && (f_ht != HMax);
      watchdog = ((h_cnt_q == HMax) && !hs_rise) || ((v_cnt_q == VMax) && !vs_rise);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q       <= '0;
         y_q       <= '0;
         h_cnt_q   <= '0;
         h_last_q  <= '0;
         v_cnt_q   <= '0;
         ref_q     <= '0;
         ref_vld_q <= 1'b0;
         bad_q     <= 1'b0;
      end else begin
         if (dv_rise) begin
            x_q <= '0;
         end else if (dv_i && (x_q != HMax)) begin
            x_q <= x_q + HOne;
         end
         if (hs_rise) begin
            h_cnt_q  <= HOne;
            h_last_q <= h_cnt_q;
         end else if (h_cnt_q != HMax) begin
            h_cnt_q <= h_cnt_q + HOne;
         end
         if (vs_rise) begin
            y_q       <= '0;
            v_cnt_q   <= '0;
            ref_vld_q <= 1'b0;
            bad_q     <= 1'b0;
         end else begin
            if (dv_fall && (y_q != VMax)) y_q <= y_q + VOne;
            if (hs_rise && (v_cnt_q != VMax)) v_cnt_q <= v_cnt_q + VOne;
            if (dv_fall) begin
               if (!ref_vld_q) begin
                  ref_q     <= line_len;
                  ref_vld_q <= 1'b1;
               end
               bad_q <= bad_q | line_bad;
            end
         end
      end
   end

   state_e        state_q, state_d;
   logic [3:0]    match_q, match_d, match_inc;
   logic [HW-1:0] cand_ha_q, cand_ht_q;
   logic [VW-1:0] cand_va_q, cand_vt_q;
   logic          cand_ld, rep_ld, locked_q, locked_d, fmt_q, fmt_d, frame_eq;

   assign match_inc = match_q + 4'd1;
   assign frame_eq  = (f_ha == cand_ha_q) && (f_va == cand_va_q) &&
                      (f_ht == cand_ht_q) && (f_vt == cand_vt_q);

   always_comb begin
      state_d  = state_q;
      match_d  = match_q;
      cand_ld  = 1'b0;
      rep_ld   = 1'b0;
      locked_d = locked_q;
      fmt_d    = 1'b0;
      if (watchdog) begin
         state_d  = StSearch;
         match_d  = '0;
         locked_d = 1'b0;
         fmt_d    = (state_q == StLocked);
      end else if (vs_rise) begin
         unique case (state_q)
            StSearch: state_d = StMeasure;
            StMeasure: begin
               if (f_ok) begin
                  cand_ld = 1'b1;
                  match_d = '0;
                  state_d = StCheck;
               end
            end
            StCheck: begin
               if (f_ok && frame_eq) begin
                  match_d = match_inc;
                  if (match_inc == 4'(LOCK_FRAMES)) begin
                     state_d  = StLocked;
                     rep_ld   = 1'b1;
                     locked_d = 1'b1;
                  end
               end else begin
                  cand_ld = 1'b1;
                  match_d = '0;
               end
            end
            StLocked: begin
               if (!(f_ok && frame_eq)) begin
                  fmt_d    = 1'b1;
                  locked_d = 1'b0;
                  cand_ld  = 1'b1;
                  match_d  = '0;
                  state_d  = StCheck;
               end
            end
            default: state_d = StSearch;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StSearch;
         match_q    <= '0;
         cand_ha_q  <= '0;
         cand_va_q  <= '0;
         cand_ht_q  <= '0;
         cand_vt_q  <= '0;
         h_active_o <= '0;
         v_active_o <= '0;
         h_total_o  <= '0;
         v_total_o  <= '0;
         locked_q   <= 1'b0;
         fmt_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         match_q  <= match_d;
         locked_q <= locked_d;
         fmt_q    <= fmt_d;
         if (cand_ld) begin
            cand_ha_q <= f_ha;
            cand_va_q <= f_va;
            cand_ht_q <= f_ht;
            cand_vt_q <= f_vt;
         end
         if (rep_ld) begin
            h_active_o <= f_ha;
            v_active_o <= f_va;
            h_total_o  <= f_ht;
            v_total_o  <= f_vt;
         end
      end
   end

   assign x_o          = x_q;
   assign y_o          = y_q;
   assign locked_o     = locked_q;
   assign fmt_change_o = fmt_q;

endmodule
